// File: rtl/des_pkg.sv
// des_pkg: shared definitions for the DES front end.
//   BLOCK_W      block width in bits (64)
//   BLOCK_BYTES  bytes per block (8)
//   block_t      block vector, DES bit numbering [0:63], byte slot i in [8*i : 8*i+7]
//   state_t      packer FSM states IDLE / FILL / PAD
//   pkcs5_fill   returns a block with slots k..7 set to the pad value 8-k
package des_pkg;

    localparam int BLOCK_W     = 64;
    localparam int BLOCK_BYTES = 8;

    typedef logic [0:BLOCK_W-1] block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2
    } state_t;

    // Block emitted after a message that ends exactly on a block boundary.
    localparam block_t PAD_BLOCK = 64'h0808_0808_0808_0808;

    // k is the number of message bytes already in the block (1..8).
    // With k = 8 the block is returned unchanged.
    function automatic block_t pkcs5_fill(block_t blk, logic [3:0] k);
        block_t     res;
        logic [7:0] pad_val;
        res     = blk;
        pad_val = 8'(BLOCK_BYTES - int'(k));
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i >= int'(k)) begin
                res[8*i +: 8] = pad_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/des_byte_packer_if.sv
// des_byte_packer_if: byte-stream input and DES-core-facing output bundle.
//   byte_i / byte_valid_i / byte_last_i / byte_ready_o  byte stream handshake
//   key_i / mode_i                                      per-message key and mode
//   data_o / key_o / mode_o / valid_o                   block strobe to the DES core
//   error_o                                             misaligned decrypt message strobe
// Modports:
//   slave   the packer (consumes bytes, drives the DES side)
//   master  the byte source / DES-side observer
interface des_byte_packer_if;
    import des_pkg::*;

    logic [7:0] byte_i;
    logic       byte_valid_i;
    logic       byte_last_i;
    logic       byte_ready_o;
    block_t     key_i;
    logic       mode_i;
    block_t     data_o;
    block_t     key_o;
    logic       mode_o;
    logic       valid_o;
    logic       error_o;

    modport slave (
        input  byte_i, byte_valid_i, byte_last_i, key_i, mode_i,
        output byte_ready_o, data_o, key_o, mode_o, valid_o, error_o
    );

    modport master (
        output byte_i, byte_valid_i, byte_last_i, key_i, mode_i,
        input  byte_ready_o, data_o, key_o, mode_o, valid_o, error_o
    );

endinterface

// File: rtl/des_byte_packer.sv
// des_byte_packer: packs a byte stream into 64-bit DES blocks.
//   clk_i    clock, rising edge
//   reset_i  synchronous active-high reset
//   bus      des_byte_packer_if.slave (byte stream in, block strobe out)
// Encrypt messages are PKCS#5 padded (an extra full pad block when the
// message ends on a block boundary). Decrypt messages that end mid-block are
// emitted zero-filled together with an error strobe. The downstream core never
// stalls, so the only input stall is the single cycle spent emitting a pad block.
module des_byte_packer
    import des_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    des_byte_packer_if.slave bus
);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    block_t     buf_q, buf_d;
    block_t     data_q, data_d;
    block_t     key_q, key_d;
    logic       mode_q, mode_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;

    logic       accept;
    logic       enc;
    block_t     blk;
    logic [3:0] fill_k;

    assign bus.byte_ready_o = !reset_i && (state_q != PAD);
    assign accept           = bus.byte_valid_i && bus.byte_ready_o;

    // The first byte of a message decides with the live mode input; later
    // bytes use the latched one so mid-message mode changes are ignored.
    assign enc = (state_q == IDLE) ? !bus.mode_i : !mode_q;

    // Working block: a new block starts from zero so an early-terminated
    // decrypt block is zero-filled without extra logic.
    always_comb begin
        blk                = (cnt_q == 3'd0) ? '0 : buf_q;
        blk[8*cnt_q +: 8]  = bus.byte_i;
        fill_k             = {1'b0, cnt_q} + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        data_d  = data_q;
        key_d   = key_q;
        mode_d  = mode_q;
        valid_d = 1'b0;
        error_d = 1'b0;

        case (state_q)
            PAD: begin
                data_d  = PAD_BLOCK;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                if (accept) begin
                    if (state_q == IDLE) begin
                        key_d  = bus.key_i;
                        mode_d = bus.mode_i;
                    end
                    buf_d   = blk;
                    cnt_d   = cnt_q + 3'd1;   // wraps to 0 on the 8th byte
                    state_d = FILL;

                    if (bus.byte_last_i) begin
                        cnt_d   = 3'd0;
                        valid_d = 1'b1;
                        state_d = IDLE;
                        if (cnt_q == 3'd7) begin
                            data_d = blk;
                            if (enc) begin
                                state_d = PAD;
                            end
                        end else if (enc) begin
                            data_d = pkcs5_fill(blk, fill_k);
                        end else begin
                            data_d  = blk;
                            error_d = 1'b1;
                        end
                    end else if (cnt_q == 3'd7) begin
                        data_d  = blk;
                        valid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            buf_q   <= '0;
            data_q  <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.key_o   = key_q;
    assign bus.mode_o  = mode_q;
    assign bus.valid_o = valid_q;
    assign bus.error_o = error_q;

endmodule

// File: tb/tb_des_byte_packer.sv
// tb_des_byte_packer: directed bench for des_byte_packer with a message-level
// reference model (expected block list per message) and a per-cycle compare.
module tb_des_byte_packer;
    import des_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    des_byte_packer_if bus();

    des_byte_packer dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic [63:0] key;
        logic        mode;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   ready_low = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Expected blocks of a whole message: full 8-byte groups, then one tail
    // block. Encrypt always has a tail (pad value 8-rem, which is 8 for an
    // aligned message); decrypt has one only when misaligned, zero-filled.
    task automatic model(input logic [7:0] msg[$], input logic mode, input logic [63:0] key);
        int   n    = msg.size();
        int   nblk = n / 8;
        int   rem  = n % 8;
        exp_t e;
        for (int b = 0; b < nblk; b++) begin
            e.data = 64'd0;
            for (int j = 0; j < 8; j++) e.data = (e.data << 8) | 64'(msg[b*8+j]);
            e.err = 1'b0; e.key = key; e.mode = mode;
            expq.push_back(e);
        end
        if (rem != 0 || mode == 1'b0) begin
            e.data = 64'd0;
            for (int j = 0; j < 8; j++) begin
                if (j < rem)   e.data = (e.data << 8) | 64'(msg[nblk*8+j]);
                else if (mode) e.data = (e.data << 8);
                else           e.data = (e.data << 8) | 64'(8 - rem);
            end
            e.err = mode && (rem != 0); e.key = key; e.mode = mode;
            expq.push_back(e);
        end
    endtask

    // Drives one message; the key/mode inputs are scrambled after the first
    // byte to show they are only sampled at message start. Returns at the
    // first negedge after the last byte is accepted.
    task automatic send(input logic [7:0] msg[$], input logic mode, input logic [63:0] key,
                        input bit use_model);
        if (use_model) model(msg, mode, key);
        for (int i = 0; i < msg.size(); i++) begin
            int w = 0;
            @(negedge clk);
            bus.byte_valid_i = 1'b1;
            bus.byte_i       = msg[i];
            bus.byte_last_i  = (i == msg.size() - 1);
            bus.key_i        = (i == 0) ? key  : ~key;
            bus.mode_i       = (i == 0) ? mode : ~mode;
            while (!bus.byte_ready_o && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) fail_now("ready_timeout");
        end
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        bus.byte_last_i  = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (expq.size() != 0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (expq.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Per-cycle compare against the model queue.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (!bus.byte_ready_o) ready_low++;
            if (bus.valid_o) begin
                if (expq.size() == 0) begin
                    fail_now("unexpected_valid");
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("blk_data", bus.data_o, e.data);
                    chk("blk_error", {63'd0, bus.error_o}, {63'd0, e.err});
                    chk("blk_key", bus.key_o, e.key);
                    chk("blk_mode", {63'd0, bus.mode_o}, {63'd0, e.mode});
                end
            end else if (bus.error_o) begin
                fail_now("error_without_valid");
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m[$];
        int rl0;

        reset = 1'b1;
        bus.byte_i = 8'd0; bus.byte_valid_i = 1'b0; bus.byte_last_i = 1'b0;
        bus.key_i = '0; bus.mode_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data",  bus.data_o, 64'd0);
        chk("rst_key",   bus.key_o,  64'd0);
        chk("rst_mode",  {63'd0, bus.mode_o},  64'd0);
        chk("rst_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("rst_error", {63'd0, bus.error_o}, 64'd0);
        chk("rst_ready_low", {63'd0, bus.byte_ready_o}, 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, bus.byte_ready_o}, 64'd1);

        // 1: encrypt 3 bytes -> 5 pad bytes
        m = '{8'hAA, 8'hBB, 8'hCC};
        send(m, 1'b0, 64'h1334_5779_9BBC_DFF1, 1'b1);
        chk("t1_valid", {63'd0, bus.valid_o}, 64'd1);
        chk("t1_data",  bus.data_o, 64'hAABB_CC05_0505_0505);
        drain();

        // 2: encrypt aligned 8 bytes -> data block then pad block back-to-back
        m.delete();
        for (int i = 1; i <= 8; i++) m.push_back(8'(i));
        rl0 = ready_low;
        send(m, 1'b0, 64'h0F0E_0D0C_0B0A_0908, 1'b1);
        chk("t2_data",      bus.data_o, 64'h0102_0304_0506_0708);
        chk("t2_ready_pad", {63'd0, bus.byte_ready_o}, 64'd0);
        @(negedge clk);
        chk("t2_pad_valid", {63'd0, bus.valid_o}, 64'd1);
        chk("t2_pad_data",  bus.data_o, 64'h0808_0808_0808_0808);
        drain();
        chk("t2_ready_low_cycles", 64'(ready_low - rl0), 64'd1);

        // 3: decrypt 16 bytes -> two blocks, no pad, no error
        m.delete();
        for (int i = 0; i < 16; i++) m.push_back(8'(i));
        send(m, 1'b1, 64'hA5A5_5A5A_0123_4567, 1'b1);
        chk("t3_data",  bus.data_o, 64'h0809_0A0B_0C0D_0E0F);
        chk("t3_error", {63'd0, bus.error_o}, 64'd0);
        drain();

        // 4: decrypt 5 bytes -> zero-filled block with error
        m = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send(m, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        chk("t4_data",  bus.data_o, 64'h1122_3344_5500_0000);
        chk("t4_error", {63'd0, bus.error_o}, 64'd1);
        drain();

        // 5: partial message aborted by reset, then a fresh 7-byte encrypt
        m = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
        send(m, 1'b1, 64'h1111_2222_3333_4444, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send(m, 1'b0, 64'h5555_6666_7777_8888, 1'b1);
        chk("t5_data", bus.data_o, 64'h8000_0000_0000_0001);
        chk("t5_key",  bus.key_o,  64'h5555_6666_7777_8888);
        chk("t5_mode", {63'd0, bus.mode_o}, 64'd0);
        drain();

        // 6: single-byte encrypt message
        m = '{8'h5A};
        send(m, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1);
        chk("t6_data", bus.data_o, 64'h5A07_0707_0707_0707);
        drain();

        // 7: block pair that feeds the DES known-answer vector
        m = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send(m, 1'b0, 64'h0101_0101_0101_0101, 1'b1);
        chk("t7_data", bus.data_o, 64'h8000_0000_0000_0000);
        chk("t7_key",  bus.key_o,  64'h0101_0101_0101_0101);
        @(negedge clk);
        chk("t7_pad",  bus.data_o, 64'h0808_0808_0808_0808);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/des_byte_packer.md
# des_byte_packer

Upstream stage of the DES core. It accepts a byte stream with a valid/ready handshake and assembles 64-bit blocks, first byte in bits [0:7]. In encrypt mode it applies PKCS#5 padding at end of message; in decrypt mode it checks block alignment. It drives the DES core's data/key/mode/valid inputs directly. The DES core accepts one block per cycle with no backpressure, so this block never stalls on its output side.

## Interface
- BLOCK_BYTES, 8, bytes per DES block (fixed; not meant to be overridden)
- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- byte_i  in  8  input byte
- byte_valid_i  in  1  byte_i valid
- byte_last_i  in  1  marks final byte of message, qualified by byte_valid_i
- byte_ready_o  out  1  byte accepted when byte_valid_i && byte_ready_o
- key_i  in  64  DES key, bits [0:63], sampled with first byte of a message
- mode_i  in  1  0 = encrypt, 1 = decrypt, sampled with first byte of a message
- data_o  out  64  assembled block, bits [0:63], to DES data_i
- key_o  out  64  latched message key, to DES key_i
- mode_o  out  1  latched message mode, to DES mode_i
- valid_o  out  1  one-cycle strobe per block, to DES valid_i
- error_o  out  1  one-cycle strobe: decrypt message not a multiple of 8 bytes

## Operation
- States: IDLE (no message open), FILL (message open, 0–7 bytes buffered), PAD (emitting a full pad block).
- IDLE: on an accepted byte, latch key_i/mode_i into key_o/mode_o and store the byte at slot 0. Go to FILL, or handle `last` immediately as below.
- FILL: each accepted byte is stored at slot cnt, bits [8*cnt : 8*cnt+7]; cnt is 3 bits.
- Block completion: when the 8th byte is accepted, the block is emitted (see Timing) and cnt wraps to 0.
- Last byte, encrypt, k bytes in current block (k = 1..7): fill slots k..7 with byte value 8-k and emit the block. Return to IDLE.
- Last byte, encrypt, k = 8: emit the data block, then go to PAD and emit 0808080808080808. Return to IDLE.
- Last byte, decrypt, k = 8: emit the block and return to IDLE.
- Last byte, decrypt, k < 8: emit the block with slots k..7 zero-filled and pulse error_o with the same valid_o. Return to IDLE.
- key_i/mode_i changes mid-message are ignored.
- byte_ready_o = 1 in IDLE and FILL, 0 in PAD and while reset_i is high.

## Timing
- Reset values: data_o = 0, key_o = 0, mode_o = 0, valid_o = 0, error_o = 0, cnt = 0, state IDLE. byte_ready_o = 1 from the first cycle after reset_i deasserts.
- All outputs are registered.
- Latency: valid_o asserts the cycle after the byte that completes a block (8th byte or last byte) is accepted.
- PAD block: valid_o asserts in the cycle following the data block, giving two consecutive valid_o cycles. byte_ready_o is low only during that one cycle.
- Throughput: one byte per cycle sustained, so one block every 8 cycles. The only stall is the single PAD cycle.
- data_o/key_o/mode_o hold their value after valid_o drops, until the next emitted block.
- Reset mid-message: the partial block is discarded, no valid_o, state returns to IDLE. The next accepted byte starts a new message.
- A byte_valid_i with byte_last_i in IDLE forms a 1-byte message: encrypt yields XX07070707070707.

## Structure
- Shared package des_pkg holds:
  - block width constant 64
  - BLOCK_BYTES = 8
  - state encoding IDLE/FILL/PAD
  - pure function pkcs5_fill(block, k) returning the block with slots k..7 set to 8-k
- No sub-module; a single flat module of about 150–250 lines.

## Test plan
- Encrypt, bytes AA BB CC with last on CC -> one valid_o, data_o = AABBCC0505050505, error_o = 0.
- Encrypt, bytes 01..08 back-to-back with last on 08 -> data_o 0102030405060708 then 0808080808080808 on consecutive cycles. byte_ready_o is low for exactly the PAD cycle.
- Decrypt, 16 bytes 00..0F, last on 0F -> blocks 0001020304050607 and 08090A0B0C0D0E0F, no pad block, error_o never asserted.
- Decrypt, 5 bytes 11 22 33 44 55 with last on 55 -> data_o = 1122334455000000 with valid_o and error_o high in the same cycle.
- Reset mid-message: 4 bytes, then reset_i high 1 cycle, then encrypt 80 00 00 00 00 00 00 with last on the 7th byte -> only 8000000000000001 emitted. key_o/mode_o are from the second message.
- Integration with the DES core:
  - encrypt message 80 00 00 00 00 00 00 00, key 0101010101010101
  - expect first DES output 95F8A5E5DD31D900
  - followed by the DES encryption of the 0808080808080808 pad block
